serial_uart_port: RTL and testbench
===================================

Name: serial_uart_port

Overview:
- UART transceiver on the processor's serial pins, directly downstream of the datapath's memory-mapped serial interface.
- Accepts bytes written by the processor (serial_out/serial_wren_out) into a TX FIFO and shifts them out 8N1.
- Deserialises the RX line into an RX FIFO that the processor reads via serial_in/serial_valid_in/serial_rden_out.
- Provides back-pressure through serial_ready_in.

Parameters:
CLKS_PER_BIT, 434, clocks per UART bit (>=4); 434 = 115200 baud at 50 MHz
FIFO_DEPTH, 16, entries per FIFO; power of two, >=2

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
serial_data_in  in  8  byte from processor (serial_out)
serial_wren_in  in  1  processor write strobe (serial_wren_out)
serial_rden_in  in  1  processor read/pop strobe (serial_rden_out)
serial_data_out  out  8  RX FIFO head (to serial_in)
serial_valid_out  out  1  RX FIFO non-empty (to serial_valid_in)
serial_ready_out  out  1  TX FIFO not full (to serial_ready_in)
uart_rx_in  in  1  asynchronous RX line, idle high
uart_tx_out  out  1  TX line, idle high
rx_overrun_out  out  1  one-cycle pulse: received byte dropped, RX FIFO full
rx_frame_err_out  out  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Reset, sampled on the clock edge, applies from any state including mid-frame:
  - FIFOs empty, FSMs IDLE.
  - uart_tx_out=1, serial_valid_out=0, serial_ready_out=1, serial_data_out=8'h00.
  - Both error pulses 0.
- TX write: accepted on a clock edge where serial_wren_in=1 and the TX FIFO is not full at the start of that cycle. A write while full is dropped silently, even if a pop occurs in the same cycle.
- serial_ready_out = !tx_full, combinational from the FIFO count.
- TX FSM states: IDLE, START, DATA, STOP. uart_tx_out is registered.
  - IDLE: if the TX FIFO is non-empty, pop into the shift register and go to START.
  - START: line 0 for CLKS_PER_BIT clocks.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT clocks; bit counter 0..7.
  - STOP: line 1 for CLKS_PER_BIT clocks. At the end of STOP, if the FIFO is non-empty, pop and go directly to START (zero idle gap); otherwise go to IDLE.
- TX latency: a write on edge N into an empty FIFO with the FSM in IDLE gives the pop on edge N+1 and uart_tx_out=0 from edge N+2.
- RX input: 2-flop synchroniser on uart_rx_in; only the synchronised value is used.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge of the synchronised line goes to START with the counter cleared.
  - START: sample at count CLKS_PER_BIT/2 (integer). If 1, treat as a glitch and return to IDLE with no flags. If 0, go to DATA.
  - DATA: sample each bit at the bit midpoint (every CLKS_PER_BIT clocks after the start sample), LSB first.
  - STOP: sample at the stop-bit midpoint.
    - Stop=1 and RX FIFO not full: push the byte.
    - Stop=1 and RX FIFO full: drop the byte and pulse rx_overrun_out, even with a simultaneous pop.
    - Stop=0: discard the byte and pulse rx_frame_err_out.
    - In all cases return to IDLE on the following clock; a new start edge is then recognised immediately.
- RX read output: serial_valid_out = !rx_empty. serial_data_out is the head entry when non-empty, 8'h00 when empty.
  - serial_valid_out rises on the edge after the stop-sample cycle.
  - serial_rden_in=1 while non-empty pops on that edge; serial_rden_in while empty is ignored.
- FIFOs: simultaneous push and pop in one cycle are both performed and the count is unchanged. Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.

Decomposition:
- Package serial_uart_pkg:
  - tx/rx state enum (IDLE, START, DATA, STOP)
  - DATA_BITS=8, LINE_IDLE=1'b1, START_BIT=1'b0
  - bit-counter width function
- Sub-module sync_fifo (WIDTH, DEPTH): push/pop/full/empty/head, synchronous reset. Instantiated twice, once for TX and once for RX.
- TX and RX FSMs stay in the top module.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset mid-frame: assert reset for 2 clocks during a TX DATA bit -> uart_tx_out=1, serial_ready_out=1, serial_valid_out=0 on the edge reset is sampled; no residual frame after release.
- Single TX 8'hA5 written at edge N -> uart_tx_out=0 from N+2, then 1,0,1,0,0,1,0,1, then stop 1, each held exactly 4 clocks; total 40 clocks.
- TX back-pressure: 6 consecutive writes 8'h01..8'h06 -> serial_ready_out=0 after the 5th, 6th dropped, exactly 5 frames 01..05 back-to-back with no idle gap.
- RX 8'h3C from bench UART model -> serial_valid_out=1 and serial_data_out=8'h3C one edge after the stop sample; one rden pulse -> valid=0, data=8'h00.
- RX glitch and framing: a 1-clock low pulse -> no push, no flags. A frame 8'h55 with stop=0 -> rx_frame_err_out pulses once, FIFO stays empty.
- RX overrun: 5 frames 8'h10..8'h14 with no reads -> FIFO holds 10,11,12,13 in order; rx_overrun_out pulses once at the 5th stop sample.

Source files
------------

// File: rtl/serial_uart_pkg.sv
// Shared types and constants for the serial UART port and its FIFOs.
package serial_uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    // Width of a counter that must reach clks-1.
    function automatic int cnt_width(input int clks);
        return (clks <= 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset. A push while full is dropped
// even if a pop happens in the same cycle; a pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_uart_port.sv
// 8N1 UART transceiver between the processor's memory-mapped serial
// interface and the serial pins, with TX and RX FIFOs.
module serial_uart_port
    import serial_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] serial_data_in,
    input  logic       serial_wren_in,
    input  logic       serial_rden_in,
    output logic [7:0] serial_data_out,
    output logic       serial_valid_out,
    output logic       serial_ready_out,
    input  logic       uart_rx_in,
    output logic       uart_tx_out,
    output logic       rx_overrun_out,
    output logic       rx_frame_err_out
);
    localparam int             CW       = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_MID  = CW'(CLKS_PER_BIT / 2);
    localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

    // ---------------- TX ----------------
    logic [7:0]    tx_head;
    logic          tx_full, tx_empty, tx_pop;
    uart_state_t   tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (serial_wren_in),
        .pop   (tx_pop),
        .din   (serial_data_in),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign serial_ready_out = !tx_full;
    // Popping at the end of STOP keeps back-to-back frames gap-free.
    assign tx_pop = !tx_empty &&
                    ((tx_state == IDLE) || (tx_state == STOP && tx_cnt == CNT_LAST));

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state    <= IDLE;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_shift    <= '0;
            uart_tx_out <= LINE_IDLE;
        end else begin
            case (tx_state)
                IDLE:  uart_tx_out <= LINE_IDLE;
                START: uart_tx_out <= START_BIT;
                DATA:  uart_tx_out <= tx_shift[0];
                STOP:  uart_tx_out <= LINE_IDLE;
            endcase
            if (tx_pop) begin
                tx_shift <= tx_head;
                tx_state <= START;
                tx_cnt   <= '0;
            end else if (tx_state != IDLE) begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt <= '0;
                    case (tx_state)
                        START: begin
                            tx_state <= DATA;
                            tx_bit   <= '0;
                        end
                        DATA: begin
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 1'b1;
                            if (tx_bit == BIT_LAST) tx_state <= STOP;
                        end
                        default: tx_state <= IDLE;
                    endcase
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
        end
    end

    // ---------------- RX ----------------
    logic [7:0]    rx_head;
    logic          rx_full, rx_empty, rx_push;
    logic          rx_s1, rx_s2, rx_prev;
    logic          stop_sample;
    uart_state_t   rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .pop   (serial_rden_in),
        .din   (rx_shift),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign serial_valid_out = !rx_empty;
    assign serial_data_out  = rx_empty ? 8'h00 : rx_head;
    assign stop_sample      = (rx_state == STOP) && (rx_cnt == CNT_LAST);
    assign rx_push          = stop_sample && rx_s2 && !rx_full;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_s1            <= LINE_IDLE;
            rx_s2            <= LINE_IDLE;
            rx_prev          <= LINE_IDLE;
            rx_state         <= IDLE;
            rx_cnt           <= '0;
            rx_bit           <= '0;
            rx_shift         <= '0;
            rx_overrun_out   <= 1'b0;
            rx_frame_err_out <= 1'b0;
        end else begin
            rx_s1            <= uart_rx_in;
            rx_s2            <= rx_s1;
            rx_prev          <= rx_s2;
            rx_overrun_out   <= stop_sample && rx_s2 && rx_full;
            rx_frame_err_out <= stop_sample && !rx_s2;
            case (rx_state)
                IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= START;
                        rx_cnt   <= '0;
                    end
                end
                START: begin
                    if (rx_cnt == CNT_MID) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        // A line already back high at mid-start is a glitch.
                        rx_state <= rx_s2 ? IDLE : DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == BIT_LAST) rx_state <= STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_uart_port.sv
// Self-checking bench for serial_uart_port: line-level UART model on both
// pins, queue-based RX FIFO model, directed plus random byte traffic.
module tb_serial_uart_port;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] serial_data_in = 8'h00;
    logic       serial_wren_in = 1'b0;
    logic       serial_rden_in = 1'b0;
    logic [7:0] serial_data_out;
    logic       serial_valid_out;
    logic       serial_ready_out;
    logic       uart_rx_in = 1'b1;
    logic       uart_tx_out;
    logic       rx_overrun_out;
    logic       rx_frame_err_out;

    int total = 0;
    int bad   = 0;

    logic       tx_log[$];
    logic [7:0] tx_exp[$];
    logic [7:0] rx_model[$];
    int         ovr_pulses = 0, ferr_pulses = 0;
    int         exp_ovr = 0, exp_ferr = 0;

    always #5 clock = ~clock;

    serial_uart_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .serial_data_in   (serial_data_in),
        .serial_wren_in   (serial_wren_in),
        .serial_rden_in   (serial_rden_in),
        .serial_data_out  (serial_data_out),
        .serial_valid_out (serial_valid_out),
        .serial_ready_out (serial_ready_out),
        .uart_rx_in       (uart_rx_in),
        .uart_tx_out      (uart_tx_out),
        .rx_overrun_out   (rx_overrun_out),
        .rx_frame_err_out (rx_frame_err_out)
    );

    // Line and pulse monitor, sampled mid-cycle.
    always @(negedge clock) begin
        tx_log.push_back(uart_tx_out);
        if (rx_overrun_out)   ovr_pulses++;
        if (rx_frame_err_out) ferr_pulses++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected line level k clocks into an 8N1 frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        int p;
        p = k / CPB;
        if (p == 0) return 1'b0;
        if (p <= 8) return b[p-1];
        return 1'b1;
    endfunction

    // Frames in tx_exp must appear back-to-back from log index start, then idle.
    task automatic check_tx(input int start, input string name);
        int errs;
        for (int f = 0; f < tx_exp.size(); f++) begin
            errs = 0;
            for (int k = 0; k < FRAME; k++)
                if (tx_log[start + f*FRAME + k] !== frame_bit(tx_exp[f], k)) errs++;
            total++;
            if (errs != 0) begin
                bad++;
                $display("FAIL %s frame%0d byte=%02h bad_clocks=%0d want=0", name, f, tx_exp[f], errs);
            end
        end
        errs = 0;
        for (int k = 0; k < 8; k++)
            if (tx_log[start + tx_exp.size()*FRAME + k] !== 1'b1) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s idle_after low_clocks=%0d want=0", name, errs);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        uart_rx_in = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rx_in = b[i];
            repeat (CPB) tick();
        end
        uart_rx_in = stop;
        repeat (CPB) tick();
        uart_rx_in = 1'b1;
        if (!stop)                         exp_ferr++;
        else if (rx_model.size() < DEPTH)  rx_model.push_back(b);
        else                               exp_ovr++;
    endtask

    task automatic read_check(input string name);
        logic [7:0] want;
        want = rx_model.pop_front();
        total++;
        if (serial_valid_out !== 1'b1 || serial_data_out !== want) begin
            bad++;
            $display("FAIL %s valid=%b data=%02h want valid=1 data=%02h", name, serial_valid_out, serial_data_out, want);
        end
        serial_rden_in = 1'b1;
        tick();
        serial_rden_in = 1'b0;
    endtask

    task automatic check_rx_empty(input string name);
        total++;
        if (serial_valid_out !== 1'b0 || serial_data_out !== 8'h00) begin
            bad++;
            $display("FAIL %s valid=%b data=%02h want valid=0 data=00", name, serial_valid_out, serial_data_out);
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        total++;
        if (uart_tx_out !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", uart_tx_out); end
        total++;
        if (serial_ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", serial_ready_out); end
        check_rx_empty("reset_rx");
        total++;
        if (rx_overrun_out !== 1'b0 || rx_frame_err_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b%b want=00", rx_overrun_out, rx_frame_err_out);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_tx();
        int base;
        serial_data_in = 8'hA5;
        serial_wren_in = 1'b1;
        tick();
        serial_wren_in = 1'b0;
        base = tx_log.size();
        repeat (2 + FRAME + 10) tick();
        total++;
        if (tx_log[base+1] !== 1'b1) begin bad++; $display("FAIL tx_latency early_start got=%b want=1", tx_log[base+1]); end
        tx_exp = {8'hA5};
        check_tx(base + 2, "single_tx");
    endtask

    task automatic test_back_pressure();
        int base = 0;
        for (int i = 1; i <= 6; i++) begin
            serial_data_in = 8'(i);
            serial_wren_in = 1'b1;
            tick();
            if (i == 1) base = tx_log.size();
            if (i == 5) begin
                total++;
                if (serial_ready_out !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b want=0", serial_ready_out); end
            end
        end
        serial_wren_in = 1'b0;
        repeat (5*FRAME + 20) tick();
        tx_exp = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_tx(base + 2, "back_pressure");
        total++;
        if (serial_ready_out !== 1'b1) begin bad++; $display("FAIL bp_ready_after got=%b want=1", serial_ready_out); end
    endtask

    task automatic test_reset_midframe();
        int base, errs;
        serial_data_in = 8'h00;
        serial_wren_in = 1'b1;
        tick();
        serial_wren_in = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        total++;
        if (uart_tx_out !== 1'b1 || serial_ready_out !== 1'b1 || serial_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL midframe_reset tx=%b ready=%b valid=%b want 1 1 0", uart_tx_out, serial_ready_out, serial_valid_out);
        end
        tick();
        reset = 1'b0;
        base = tx_log.size();
        repeat (60) tick();
        errs = 0;
        for (int k = 0; k < 55; k++) if (tx_log[base+k] !== 1'b1) errs++;
        total++;
        if (errs != 0) begin bad++; $display("FAIL midframe_residual low_clocks=%0d want=0", errs); end
    endtask

    task automatic test_rx_single();
        int n = 0;
        send_rx(8'h3C, 1'b1);
        total++;
        if (serial_valid_out !== 1'b0) begin bad++; $display("FAIL rx_early_valid got=%b want=0", serial_valid_out); end
        while (serial_valid_out !== 1'b1 && n < 10) begin tick(); n++; end
        read_check("rx_3c");
        check_rx_empty("rx_after_pop");
    endtask

    task automatic test_rx_errors();
        int o0 = ovr_pulses, f0 = ferr_pulses, ef0 = exp_ferr;
        uart_rx_in = 1'b0;
        tick();
        uart_rx_in = 1'b1;
        repeat (15) tick();
        check_rx_empty("rx_glitch");
        total++;
        if (ovr_pulses != o0 || ferr_pulses != f0) begin
            bad++;
            $display("FAIL rx_glitch_flags ovr=%0d ferr=%0d want=0 0", ovr_pulses - o0, ferr_pulses - f0);
        end
        send_rx(8'h55, 1'b0);
        repeat (8) tick();
        total++;
        if (ferr_pulses - f0 != exp_ferr - ef0) begin
            bad++;
            $display("FAIL rx_frame_err pulses=%0d want=%0d", ferr_pulses - f0, exp_ferr - ef0);
        end
        check_rx_empty("rx_frame_err_fifo");
    endtask

    task automatic test_rx_overrun();
        int o0 = ovr_pulses, e0 = exp_ovr;
        for (int i = 0; i < 5; i++) send_rx(8'h10 + 8'(i), 1'b1);
        repeat (8) tick();
        total++;
        if (ovr_pulses - o0 != exp_ovr - e0) begin
            bad++;
            $display("FAIL rx_overrun pulses=%0d want=%0d", ovr_pulses - o0, exp_ovr - e0);
        end
        for (int i = 0; i < DEPTH; i++) read_check("rx_overrun_order");
        check_rx_empty("rx_overrun_drained");
    endtask

    task automatic test_random();
        int base = 0;
        for (int i = 0; i < 3; i++) send_rx(8'($urandom_range(0, 255)), 1'b1);
        repeat (8) tick();
        for (int i = 0; i < 3; i++) read_check("rx_random");
        check_rx_empty("rx_random_drained");
        tx_exp = {};
        for (int i = 0; i < 3; i++) begin
            tx_exp.push_back(8'($urandom_range(0, 255)));
            serial_data_in = tx_exp[i];
            serial_wren_in = 1'b1;
            tick();
            if (i == 0) base = tx_log.size();
        end
        serial_wren_in = 1'b0;
        repeat (3*FRAME + 20) tick();
        check_tx(base + 2, "tx_random");
    endtask

    initial begin
        test_reset();
        test_single_tx();
        test_back_pressure();
        test_reset_midframe();
        test_rx_single();
        test_rx_errors();
        test_rx_overrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
